// File: rtl/siphash_core_param.sv
// SipHash core with ROUNDS_PER_CYCLE SipRounds unrolled per clock, run-time
// selectable 64/128-bit tag and zero-round support for c and d.
module siphash_core_param #(
   parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         initialize,
   input  logic         compress,
   input  logic         finalize,
   input  logic         long_mode,
   input  logic [3:0]   c,
   input  logic [3:0]   d,
   input  logic [127:0] k,
   input  logic [63:0]  mi,
   output logic         ready,
   output logic [127:0] siphash_word,
   output logic         siphash_word_valid
);

   localparam int unsigned WORD_W = 64;
   localparam int unsigned TAG_W  = 128;
   localparam int unsigned CNT_W  = 4;
   localparam logic [CNT_W-1:0] R_CNT = CNT_W'(ROUNDS_PER_CYCLE);

   typedef enum logic [2:0] {
      IDLE,
      COMP_ROUND,
      COMP_END,
      FIN_ROUND_0,
      FIN_OUT_0,
      FIN_ROUND_1,
      FIN_OUT_1
   } state_t;

   typedef struct packed {
      logic [WORD_W-1:0] v0;
      logic [WORD_W-1:0] v1;
      logic [WORD_W-1:0] v2;
      logic [WORD_W-1:0] v3;
   } vstate_t;

   function automatic logic [WORD_W-1:0] rotl(input logic [WORD_W-1:0] x, input int unsigned s);
      return (x << s) | (x >> (WORD_W - s));
   endfunction

   function automatic vstate_t sip_round(input vstate_t vi);
      vstate_t vo;
      vo = vi;
      vo.v0 = vo.v0 + vo.v1;
      vo.v1 = rotl(vo.v1, 13) ^ vo.v0;
      vo.v0 = rotl(vo.v0, 32);
      vo.v2 = vo.v2 + vo.v3;
      vo.v3 = rotl(vo.v3, 16) ^ vo.v2;
      vo.v0 = vo.v0 + vo.v3;
      vo.v3 = rotl(vo.v3, 21) ^ vo.v0;
      vo.v2 = vo.v2 + vo.v1;
      vo.v1 = rotl(vo.v1, 17) ^ vo.v2;
      vo.v2 = rotl(vo.v2, 32);
      return vo;
   endfunction

   state_t             state_r, state_nxt;
   vstate_t            v_r, v_nxt;
   logic [WORD_W-1:0]  mi_r, mi_nxt;
   logic               mode_r, mode_nxt;
   logic [CNT_W-1:0]   ctr_r, ctr_nxt;
   logic [CNT_W-1:0]   d_r, d_nxt;
   logic [TAG_W-1:0]   word_r, word_nxt;
   logic               valid_r, valid_nxt;
   logic               ready_r, ready_nxt;

   logic [CNT_W-1:0]   n_rounds;
   vstate_t            rnd_out;
   logic [WORD_W-1:0]  v_xor;

   assign v_xor = v_r.v0 ^ v_r.v1 ^ v_r.v2 ^ v_r.v3;

   // Unrolled round chain; the stage matching min(R, remaining) is selected
   always_comb begin
      vstate_t st;
      n_rounds = (ctr_r > R_CNT) ? R_CNT : ctr_r;
      st       = v_r;
      rnd_out  = v_r;
      for (int unsigned i = 0; i < ROUNDS_PER_CYCLE; i++) begin
         st = sip_round(st);
         if (CNT_W'(i + 1) == n_rounds) rnd_out = st;
      end
   end

   // Next-state, datapath and output decode
   always_comb begin
      state_nxt = state_r;
      v_nxt     = v_r;
      mi_nxt    = mi_r;
      mode_nxt  = mode_r;
      ctr_nxt   = ctr_r;
      d_nxt     = d_r;
      word_nxt  = word_r;
      valid_nxt = valid_r;

      case (state_r)
         IDLE: begin
            if (initialize) begin
               v_nxt.v0  = k[63:0]   ^ 64'h736f6d6570736575;
               v_nxt.v1  = k[127:64] ^ 64'h646f72616e646f6d ^ {56'd0, (long_mode ? 8'hee : 8'h00)};
               v_nxt.v2  = k[63:0]   ^ 64'h6c7967656e657261;
               v_nxt.v3  = k[127:64] ^ 64'h7465646279746573;
               mode_nxt  = long_mode;
               valid_nxt = 1'b0;
            end else if (compress) begin
               mi_nxt    = mi;
               v_nxt.v3  = v_r.v3 ^ mi;
               ctr_nxt   = c;
               valid_nxt = 1'b0;
               state_nxt = (c == '0) ? COMP_END : COMP_ROUND;
            end else if (finalize) begin
               v_nxt.v2  = v_r.v2 ^ {56'd0, (mode_r ? 8'hee : 8'hff)};
               ctr_nxt   = d;
               d_nxt     = d;
               valid_nxt = 1'b0;
               state_nxt = (d == '0) ? FIN_OUT_0 : FIN_ROUND_0;
            end
         end
         COMP_ROUND: begin
            v_nxt   = rnd_out;
            ctr_nxt = ctr_r - n_rounds;
            if (ctr_r <= R_CNT) state_nxt = COMP_END;
         end
         COMP_END: begin
            v_nxt.v0  = v_r.v0 ^ mi_r;
            state_nxt = IDLE;
         end
         FIN_ROUND_0: begin
            v_nxt   = rnd_out;
            ctr_nxt = ctr_r - n_rounds;
            if (ctr_r <= R_CNT) state_nxt = FIN_OUT_0;
         end
         FIN_OUT_0: begin
            word_nxt[63:0] = v_xor;
            if (mode_r) begin
               v_nxt.v1  = v_r.v1 ^ 64'h00000000000000dd;
               ctr_nxt   = d_r;
               state_nxt = (d_r == '0) ? FIN_OUT_1 : FIN_ROUND_1;
            end else begin
               word_nxt[127:64] = '0;
               valid_nxt        = 1'b1;
               state_nxt        = IDLE;
            end
         end
         FIN_ROUND_1: begin
            v_nxt   = rnd_out;
            ctr_nxt = ctr_r - n_rounds;
            if (ctr_r <= R_CNT) state_nxt = FIN_OUT_1;
         end
         FIN_OUT_1: begin
            word_nxt[127:64] = v_xor;
            valid_nxt        = 1'b1;
            state_nxt        = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      ready_nxt = (state_nxt == IDLE);
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
         v_r     <= '0;
         mi_r    <= '0;
         mode_r  <= 1'b0;
         ctr_r   <= '0;
         d_r     <= '0;
         word_r  <= '0;
         valid_r <= 1'b0;
         ready_r <= 1'b1;
      end else begin
         state_r <= state_nxt;
         v_r     <= v_nxt;
         mi_r    <= mi_nxt;
         mode_r  <= mode_nxt;
         ctr_r   <= ctr_nxt;
         d_r     <= d_nxt;
         word_r  <= word_nxt;
         valid_r <= valid_nxt;
         ready_r <= ready_nxt;
      end
   end

   assign ready              = ready_r;
   assign siphash_word       = word_r;
   assign siphash_word_valid = valid_r;

endmodule

// File: tb/tb_siphash_core_param.sv
// Randomised scoreboard bench for siphash_core_param against a sequential SipHash model.
module tb_siphash_core_param;

   localparam int unsigned RPC = 2;

   logic         clk;
   logic         reset_n;
   logic         initialize;
   logic         compress;
   logic         finalize;
   logic         long_mode;
   logic [3:0]   c;
   logic [3:0]   d;
   logic [127:0] k;
   logic [63:0]  mi;
   logic         ready;
   logic [127:0] siphash_word;
   logic         siphash_word_valid;

   siphash_core_param #(.ROUNDS_PER_CYCLE(RPC)) dut (
      .clk                (clk),
      .reset_n            (reset_n),
      .initialize         (initialize),
      .compress           (compress),
      .finalize           (finalize),
      .long_mode          (long_mode),
      .c                  (c),
      .d                  (d),
      .k                  (k),
      .mi                 (mi),
      .ready              (ready),
      .siphash_word       (siphash_word),
      .siphash_word_valid (siphash_word_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int           n_vec = 0;
   int           n_err = 0;
   logic [127:0] exp_q[$];
   logic         mon_prev;

   // Reference model state
   logic [63:0]  m_v[4];
   logic         m_mode;

   logic [127:0] key;
   logic [63:0]  msg;
   logic [127:0] tag;
   logic [127:0] last_tag;
   int           nw;
   int           busy;

   function automatic logic [63:0] rotl(input logic [63:0] x, input int s);
      return (x << s) | (x >> (64 - s));
   endfunction

   function automatic int nrc(input int x);
      return (x + RPC - 1) / RPC;
   endfunction

   function automatic void m_round();
      m_v[0] += m_v[1]; m_v[1] = rotl(m_v[1], 13); m_v[1] ^= m_v[0]; m_v[0] = rotl(m_v[0], 32);
      m_v[2] += m_v[3]; m_v[3] = rotl(m_v[3], 16); m_v[3] ^= m_v[2];
      m_v[0] += m_v[3]; m_v[3] = rotl(m_v[3], 21); m_v[3] ^= m_v[0];
      m_v[2] += m_v[1]; m_v[1] = rotl(m_v[1], 17); m_v[1] ^= m_v[2]; m_v[2] = rotl(m_v[2], 32);
   endfunction

   function automatic void m_init(input logic [127:0] kk, input logic lm);
      m_v[0] = kk[63:0]   ^ 64'h736f6d6570736575;
      m_v[1] = kk[127:64] ^ 64'h646f72616e646f6d ^ (lm ? 64'hee : 64'h0);
      m_v[2] = kk[63:0]   ^ 64'h6c7967656e657261;
      m_v[3] = kk[127:64] ^ 64'h7465646279746573;
      m_mode = lm;
   endfunction

   function automatic void m_compress(input logic [63:0] m, input int rounds);
      m_v[3] ^= m;
      for (int i = 0; i < rounds; i++) m_round();
      m_v[0] ^= m;
   endfunction

   function automatic logic [127:0] m_finalize(input int rounds);
      logic [63:0] lo;
      logic [63:0] hi;
      m_v[2] ^= (m_mode ? 64'hee : 64'hff);
      for (int i = 0; i < rounds; i++) m_round();
      lo = m_v[0] ^ m_v[1] ^ m_v[2] ^ m_v[3];
      hi = 64'h0;
      if (m_mode) begin
         m_v[1] ^= 64'hdd;
         for (int i = 0; i < rounds; i++) m_round();
         hi = m_v[0] ^ m_v[1] ^ m_v[2] ^ m_v[3];
      end
      return {hi, lo};
   endfunction

   function automatic void m_reset();
      for (int i = 0; i < 4; i++) m_v[i] = 64'h0;
      m_mode = 1'b0;
   endfunction

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Issue one command pulse at a negedge and measure how long ready stays low
   task automatic cmd_wait(input logic i, input logic cm, input logic f, input int exp_busy, input string nm);
      int b;
      b = 0;
      initialize = i; compress = cm; finalize = f;
      @(negedge clk);
      initialize = 1'b0; compress = 1'b0; finalize = 1'b0;
      while (ready !== 1'b1 && b < 200) begin
         @(negedge clk);
         b++;
      end
      check(nm, 128'(b), 128'(exp_busy));
   endtask

   task automatic do_init(input logic [127:0] kk, input logic lm);
      k = kk; long_mode = lm;
      m_init(kk, lm);
      cmd_wait(1'b1, 1'b0, 1'b0, 0, "init_busy");
   endtask

   task automatic do_comp(input logic [63:0] m, input int cc);
      mi = m; c = 4'(cc);
      m_compress(m, cc);
      cmd_wait(1'b0, 1'b1, 1'b0, nrc(cc) + 1, "comp_busy");
   endtask

   task automatic do_fin(input int dd, input logic use_kat, input logic [127:0] kat);
      logic [127:0] t;
      int eb;
      d = 4'(dd);
      eb = m_mode ? (2 * nrc(dd) + 2) : (nrc(dd) + 1);
      t = m_finalize(dd);
      last_tag = use_kat ? kat : t;
      exp_q.push_back(last_tag);
      cmd_wait(1'b0, 1'b0, 1'b1, eb, "fin_busy");
   endtask

   // Monitor: compare each new tag presentation against the scoreboard
   initial begin
      mon_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (siphash_word_valid === 1'b1 && mon_prev !== 1'b1) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_tag: got %h expected no tag", siphash_word);
            end else begin
               check("tag", siphash_word, exp_q.pop_front());
            end
         end
         mon_prev = siphash_word_valid;
      end
   end

   // Stimulus
   initial begin
      reset_n = 1'b0; initialize = 1'b0; compress = 1'b0; finalize = 1'b0;
      long_mode = 1'b0; c = 4'd0; d = 4'd0; k = '0; mi = '0;
      m_reset();
      last_tag = '0;
      repeat (2) @(negedge clk);
      check("rst_ready", 128'(ready), 128'(1'b1));
      check("rst_valid", 128'(siphash_word_valid), 128'(1'b0));
      check("rst_word", siphash_word, 128'h0);
      reset_n = 1'b1;
      @(negedge clk);

      // Known-answer SipHash-2-4, 64-bit then 128-bit
      key = {64'h0f0e0d0c0b0a0908, 64'h0706050403020100};
      do_init(key, 1'b0);
      do_comp(64'h0, 2);
      do_fin(4, 1'b1, {64'h0, 64'h726fdb47dd0e0e31});
      do_comp(64'h1234, 3);
      check("hold_word", siphash_word, {64'h0, 64'h726fdb47dd0e0e31});
      check("hold_valid_clr", 128'(siphash_word_valid), 128'(1'b0));
      do_init(key, 1'b1);
      do_comp(64'h0, 2);
      do_fin(4, 1'b1, {64'h930255c71472f66d, 64'he6a825ba047f81a3});

      // Zero rounds for c and d
      key = {$urandom, $urandom, $urandom, $urandom};
      msg = {$urandom, $urandom};
      do_init(key, 1'b0);
      do_comp(msg, 0);
      do_fin(0, 1'b0, '0);
      do_init(key, 1'b1);
      do_comp(msg, 0);
      do_fin(0, 1'b0, '0);

      // Commands pulsed while busy must be ignored
      key = {$urandom, $urandom, $urandom, $urandom};
      msg = {$urandom, $urandom};
      do_init(key, 1'b0);
      mi = msg; c = 4'd15;
      m_compress(msg, 15);
      compress = 1'b1;
      @(negedge clk);
      compress = 1'b0;
      k = ~key; long_mode = 1'b1; mi = ~msg; c = 4'd1; d = 4'd1;
      initialize = 1'b1; @(negedge clk); initialize = 1'b0;
      compress = 1'b1;   @(negedge clk); compress = 1'b0;
      finalize = 1'b1;   @(negedge clk); finalize = 1'b0;
      busy = 3;
      while (ready !== 1'b1 && busy < 200) begin
         @(negedge clk);
         busy++;
      end
      check("busy_ignore", 128'(busy), 128'(nrc(15) + 1));
      do_fin(4, 1'b0, '0);

      // Simultaneous initialize and compress: only initialize takes effect
      key = {$urandom, $urandom, $urandom, $urandom};
      k = key; long_mode = 1'b0; mi = {$urandom, $urandom}; c = 4'd2;
      m_init(key, 1'b0);
      cmd_wait(1'b1, 1'b1, 1'b0, 0, "init_comp_busy");
      do_comp(64'h0000000000000011, 2);
      do_fin(4, 1'b0, '0);

      // Reset asserted mid-finalization
      do_init(key, 1'b1);
      do_comp({$urandom, $urandom}, 5);
      d = 4'd15;
      finalize = 1'b1; @(negedge clk); finalize = 1'b0;
      repeat (3) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("abort_ready", 128'(ready), 128'(1'b1));
      check("abort_valid", 128'(siphash_word_valid), 128'(1'b0));
      check("abort_word", siphash_word, 128'h0);
      m_reset();
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      do_fin(2, 1'b0, '0);
      do_init({64'h0f0e0d0c0b0a0908, 64'h0706050403020100}, 1'b0);
      do_comp(64'h0, 2);
      do_fin(4, 1'b1, {64'h0, 64'h726fdb47dd0e0e31});

      // Randomised runs
      for (int it = 0; it < 30; it++) begin
         key = {$urandom, $urandom, $urandom, $urandom};
         do_init(key, 1'(($urandom_range(0, 1))));
         nw = $urandom_range(1, 3);
         for (int w = 0; w < nw; w++) begin
            msg = {$urandom, $urandom};
            do_comp(msg, $urandom_range(0, 15));
         end
         do_fin($urandom_range(0, 15), 1'b0, '0);
      end

      repeat (3) @(negedge clk);
      check("queue_drained", 128'(exp_q.size()), 128'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
